// File: rtl/systolic_tile_core.sv
// -----------------------------------------------------------------------------
// systolic_tile_core
//
// Parametrised N x N output-stationary systolic matrix-multiply tile.
// Each accepted input beat carries one A column vector and one B row vector.
// PE(i,j) accumulates the product of its two operands into its own result.
// Operands enter the array skewed. a[i] is delayed i cycles and b[j] is
// delayed j cycles. With that skew, every operand pair of one beat meets in
// PE(i,j) in the same cycle. After the last beat, the array is flushed for
// 2N-1 cycles. The N*N results are then drained row-major over a valid/ready
// stream.
//
// Optional feature (compile-time macro SATURATE_EN):
//   defined   - accumulators clamp to the signed AW-bit range; per-PE sticky
//               saturation bits are reported on out_sat
//   undefined - accumulators wrap modulo 2^AW; out_sat is tied low
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, k_len         job start pulse (honoured in IDLE only), beat count
//   in_valid/in_ready    operand beat handshake; in_a / in_b packed vectors
//   out_valid/out_ready  result handshake; out_data = C[out_row][out_col]
//   out_last             marks element (N-1,N-1)
//   out_sat              saturation flag of the presented element
//   busy                 high whenever the core is not IDLE
//   done                 one-cycle pulse after the final result handshake
// -----------------------------------------------------------------------------
module systolic_tile_core #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int KW = 16,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_data,
    output logic [RW-1:0]   out_row,
    output logic [RW-1:0]   out_col,
    output logic            out_last,
    output logic            out_sat,
    output logic            busy,
    output logic            done
);

    localparam int FW = $clog2(2 * N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;

    logic [KW-1:0] k_len_r, beat_cnt_r;
    logic [FW-1:0] flush_cnt_r;
    logic [RW-1:0] row_r, col_r, row_nxt_s, col_nxt_s;
    logic          accept_s, clear_s, acc_en_s, adv_s, last_idx_s;
    logic          in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
    logic [AW-1:0] out_data_r;

    // a_sh_r[i][d]: stage d of the input delay line for row i (tap at d = i)
    logic signed [DW-1:0] a_sh_r   [N][N];
    logic signed [DW-1:0] b_sh_r   [N][N];
    logic signed [DW-1:0] a_pipe_r [N][N];
    logic signed [DW-1:0] b_pipe_r [N][N];
    logic signed [DW-1:0] a_in_s   [N][N];
    logic signed [DW-1:0] b_in_s   [N][N];
    logic        [AW-1:0] acc_r     [N][N];
    logic        [AW-1:0] acc_nxt_s [N][N];
`ifdef SATURATE_EN
    logic                 sat_r     [N][N];
    logic                 sat_nxt_s [N][N];
    logic                 out_sat_r;
`endif

`ifdef SATURATE_EN
    // Signed add with clamping; bit AW of the result flags a clamp.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc, input logic [AW-1:0] inc);
        logic [AW:0] sum;
        sum = {acc[AW-1], acc} + {inc[AW-1], inc};
        if (sum[AW] != sum[AW-1]) begin
            // overflow: clamp toward the sign of the exact sum
            sat_add = {1'b1, sum[AW], {(AW-1){~sum[AW]}}};
        end else begin
            sat_add = {1'b0, sum[AW-1:0]};
        end
    endfunction
`else
    // Modulo-2^AW accumulate.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] acc, input logic [AW-1:0] inc);
        wrap_add = acc + inc;
    endfunction
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        clear_s     = 1'b0;
        acc_en_s    = 1'b0;
        adv_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    clear_s     = 1'b1;
                    state_nxt_s = (k_len != {KW{1'b0}}) ? S_LOAD : S_DRAIN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                acc_en_s = 1'b1;
                accept_s = in_valid && in_ready_r;
                if (accept_s && (beat_cnt_r == k_len_r - KW'(1))) begin
                    state_nxt_s = S_FLUSH;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_FLUSH: begin
                acc_en_s = 1'b1;
                if (flush_cnt_r == FW'(2 * N - 2)) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_FLUSH;
                end
            end
            S_DRAIN: begin
                adv_s = out_ready;
                if (adv_s && last_idx_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Row-major successor of the presented result index
    always_comb begin
        last_idx_s = (row_r == RW'(N - 1)) && (col_r == RW'(N - 1));
        if (col_r == RW'(N - 1)) begin
            col_nxt_s = {RW{1'b0}};
            row_nxt_s = row_r + RW'(1);
        end else begin
            col_nxt_s = col_r + RW'(1);
            row_nxt_s = row_r;
        end
    end

    // Beat and flush counters, latched job length
    always_ff @(posedge clk) begin
        if (reset) begin
            k_len_r     <= {KW{1'b0}};
            beat_cnt_r  <= {KW{1'b0}};
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            if (clear_s) begin
                k_len_r    <= k_len;
                beat_cnt_r <= {KW{1'b0}};
            end else if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + KW'(1);
            end
            if (state_r == S_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FW'(1);
            end else begin
                flush_cnt_r <= {FW{1'b0}};
            end
        end
    end

    // PE operand routing: left/top edge from the skew taps, else from the neighbour
    always_comb begin
        logic signed [2*DW-1:0] prod_v;
        logic        [AW-1:0]   inc_v;
`ifdef SATURATE_EN
        logic        [AW:0]     sum_v;
`endif
        prod_v = {(2*DW){1'b0}};
        inc_v  = {AW{1'b0}};
`ifdef SATURATE_EN
        sum_v  = {(AW+1){1'b0}};
`endif
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_in_s[i][j] = (j == 0) ? a_sh_r[i][i] : a_pipe_r[i][(j > 0) ? j - 1 : 0];
                b_in_s[i][j] = (i == 0) ? b_sh_r[j][j] : b_pipe_r[(i > 0) ? i - 1 : 0][j];
                prod_v = (2*DW)'(a_in_s[i][j]) * (2*DW)'(b_in_s[i][j]);
                inc_v  = AW'(prod_v);
`ifdef SATURATE_EN
                sum_v = sat_add(acc_r[i][j], inc_v);
                if (acc_en_s) begin
                    acc_nxt_s[i][j] = sum_v[AW-1:0];
                    sat_nxt_s[i][j] = sat_r[i][j] | sum_v[AW];
                end else begin
                    acc_nxt_s[i][j] = acc_r[i][j];
                    sat_nxt_s[i][j] = sat_r[i][j];
                end
`else
                if (acc_en_s) begin
                    acc_nxt_s[i][j] = wrap_add(acc_r[i][j], inc_v);
                end else begin
                    acc_nxt_s[i][j] = acc_r[i][j];
                end
`endif
            end
        end
    end

    // Skew delay lines, operand pipes and accumulators; cleared on job start
    always_ff @(posedge clk) begin
        if (reset || clear_s) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_sh_r[i][j]   <= {DW{1'b0}};
                    b_sh_r[i][j]   <= {DW{1'b0}};
                    a_pipe_r[i][j] <= {DW{1'b0}};
                    b_pipe_r[i][j] <= {DW{1'b0}};
                    acc_r[i][j]    <= {AW{1'b0}};
`ifdef SATURATE_EN
                    sat_r[i][j]    <= 1'b0;
`endif
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                // cycles without an accepted beat inject zeros
                a_sh_r[i][0] <= accept_s ? in_a[i*DW +: DW] : {DW{1'b0}};
                b_sh_r[i][0] <= accept_s ? in_b[i*DW +: DW] : {DW{1'b0}};
                for (int d = 1; d < N; d++) begin
                    a_sh_r[i][d] <= a_sh_r[i][d-1];
                    b_sh_r[i][d] <= b_sh_r[i][d-1];
                end
                for (int j = 0; j < N; j++) begin
                    a_pipe_r[i][j] <= a_in_s[i][j];
                    b_pipe_r[i][j] <= b_in_s[i][j];
                    acc_r[i][j]    <= acc_nxt_s[i][j];
`ifdef SATURATE_EN
                    sat_r[i][j]    <= sat_nxt_s[i][j];
`endif
                end
            end
        end
    end

    // Registered stream and status outputs; results taken from acc_nxt_s so the
    // final accumulate (same edge as DRAIN entry) is already visible
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {AW{1'b0}};
            row_r       <= {RW{1'b0}};
            col_r       <= {RW{1'b0}};
`ifdef SATURATE_EN
            out_sat_r   <= 1'b0;
`endif
        end else begin
            in_ready_r <= (state_nxt_s == S_LOAD);
            busy_r     <= (state_nxt_s != S_IDLE);
            done_r     <= (state_r == S_DRAIN) && (state_nxt_s == S_IDLE);
            if ((state_r != S_DRAIN) && (state_nxt_s == S_DRAIN)) begin
                out_valid_r <= 1'b1;
                row_r       <= {RW{1'b0}};
                col_r       <= {RW{1'b0}};
                out_last_r  <= (N == 1);
                // a zero-length job enters DRAIN from IDLE while clearing
                out_data_r  <= clear_s ? {AW{1'b0}} : acc_nxt_s[0][0];
`ifdef SATURATE_EN
                out_sat_r   <= clear_s ? 1'b0 : sat_nxt_s[0][0];
`endif
            end else if (adv_s) begin
                if (last_idx_s) begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_data_r  <= {AW{1'b0}};
                    row_r       <= {RW{1'b0}};
                    col_r       <= {RW{1'b0}};
`ifdef SATURATE_EN
                    out_sat_r   <= 1'b0;
`endif
                end else begin
                    row_r      <= row_nxt_s;
                    col_r      <= col_nxt_s;
                    out_last_r <= (row_nxt_s == RW'(N - 1)) && (col_nxt_s == RW'(N - 1));
                    out_data_r <= acc_nxt_s[row_nxt_s][col_nxt_s];
`ifdef SATURATE_EN
                    out_sat_r  <= sat_nxt_s[row_nxt_s][col_nxt_s];
`endif
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_row   = row_r;
    assign out_col   = col_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
`ifdef SATURATE_EN
    assign out_sat   = out_sat_r;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_tile_core.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_core
//
// Directed self-checking bench for systolic_tile_core. A 2x2, 32-bit instance
// runs the functional jobs. A 2x2, 16-bit instance runs the saturation job.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_systolic_tile_core;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int KW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            start16 = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_a = '0;
    logic [N*DW-1:0] in_b = '0;
    logic            out_ready = 1'b0;

    logic            in_ready, out_valid, out_last, out_sat, busy, done;
    logic [AW-1:0]   out_data;
    logic [0:0]      out_row, out_col;

    logic            in_ready16, out_valid16, out_last16, out_sat16, busy16, done16;
    logic [15:0]     out_data16;
    logic [0:0]      out_row16, out_col16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int     ba [0:3][0:1];
    int     bb [0:3][0:1];
    longint exp_c [0:3];

    systolic_tile_core #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .out_sat(out_sat), .busy(busy), .done(done)
    );

    systolic_tile_core #(.N(N), .DW(DW), .AW(16), .KW(KW)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_row(out_row16), .out_col(out_col16), .out_last(out_last16),
        .out_sat(out_sat16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic set_beat(input int k, input int a0, input int a1, input int b0, input int b1);
        ba[k][0] = a0; ba[k][1] = a1;
        bb[k][0] = b0; bb[k][1] = b1;
    endtask

    task automatic set_exp(input longint c0, input longint c1, input longint c2, input longint c3);
        exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
    endtask

    // Run one job on the 32-bit instance. Cycle 0 is the start cycle.
    // exp_first < 0 skips the latency checks.
    task automatic run_job(input string tag, input int k, input bit bubbles, input bit stalls,
                           input bit drain_start, input int exp_first, input int exp_done);
        int bi, oi, t0, c, first_v, done_cyc, last_hs;
        bit saw_ready;
        bi = 0; oi = 0; first_v = -1; done_cyc = -1; last_hs = -2; saw_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        t0 = cyc;
        for (int n = 0; n < 300 && done_cyc < 0; n++) begin
            @(negedge clk);
            c = cyc - t0;
            start = 1'b0;
            if (in_ready) saw_ready = 1'b1;
            if (bi < k && in_ready && (!bubbles || c[0])) begin
                in_valid = 1'b1;
                in_a = {DW'(ba[bi][1]), DW'(ba[bi][0])};
                in_b = {DW'(bb[bi][1]), DW'(bb[bi][0])};
            end else begin
                // garbage that must never be accepted
                in_valid = (bi >= k);
                in_a = 16'h5a5a;
                in_b = 16'ha5a5;
            end
            if (in_valid && in_ready) bi++;
            out_ready = stalls ? c[0] : 1'b1;
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                if (oi < 4) begin
                    check($sformatf("%s.data%0d", tag, oi), $signed(out_data), exp_c[oi]);
                    check($sformatf("%s.row%0d", tag, oi), out_row, oi / 2);
                    check($sformatf("%s.col%0d", tag, oi), out_col, oi % 2);
                    check($sformatf("%s.last%0d", tag, oi), out_last, (oi == 3) ? 1 : 0);
                    check($sformatf("%s.sat%0d", tag, oi), out_sat, 0);
                end else begin
                    check($sformatf("%s.extra_out", tag), oi, 3);
                end
                if (drain_start && oi == 1) begin
                    start = 1'b1;
                    k_len = KW'(1);
                end
                if (out_ready) begin
                    oi++;
                    last_hs = c;
                end
            end
            if (done) done_cyc = c;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check($sformatf("%s.count", tag), oi, 4);
        check($sformatf("%s.done_after_last", tag), done_cyc, last_hs + 1);
        check($sformatf("%s.busy_at_done", tag), busy, 0);
        if (exp_first >= 0) begin
            check($sformatf("%s.first_valid_cycle", tag), first_v, exp_first);
            check($sformatf("%s.done_cycle", tag), done_cyc, exp_done);
        end
        if (k == 0) check($sformatf("%s.in_ready_seen", tag), saw_ready, 0);
        @(negedge clk);
        check($sformatf("%s.done_one_cycle", tag), done, 0);
    endtask

    // Saturation job on the 16-bit instance: K=4, all operands 127.
    task automatic run_sat();
        int cnt;
        bit fin;
        longint want_d;
        longint want_s;
`ifdef SATURATE_EN
        want_d = 32767;
        want_s = 1;
`else
        want_d = -1020;
        want_s = 0;
`endif
        cnt = 0; fin = 1'b0;
        @(negedge clk);
        start16 = 1'b1;
        k_len = KW'(4);
        in_valid = 1'b1;
        in_a = {8'd127, 8'd127};
        in_b = {8'd127, 8'd127};
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !fin; n++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (out_valid16) begin
                check($sformatf("sat.data%0d", cnt), $signed(out_data16), want_d);
                check($sformatf("sat.flag%0d", cnt), out_sat16, want_s);
                cnt++;
            end
            if (done16) fin = 1'b1;
        end
        in_valid = 1'b0;
        check("sat.count", cnt, 4);
        check("sat.done_seen", fin, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_last", out_last, 0);
        check("rst.out_sat", out_sat, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.out_data", out_data, 0);
        check("rst.out_row", out_row, 0);
        check("rst.out_col", out_col, 0);
        reset = 1'b0;
        @(negedge clk);

        // identity
        set_beat(0, 1, 0, 5, 6);
        set_beat(1, 0, 1, 7, 8);
        set_exp(5, 6, 7, 8);
        run_job("ident", 2, 1'b0, 1'b0, 1'b0, 6, 10);

        // signed extremes
        set_beat(0, -128, 127, -128, 127);
        set_exp(16384, -16256, -16256, 16129);
        run_job("extreme", 1, 1'b0, 1'b0, 1'b0, 5, 9);

        // mixed K=3, bubble-free, then with bubbles and backpressure
        set_beat(0, 1, 2, 3, 4);
        set_beat(1, -1, 5, 2, -3);
        set_beat(2, 4, -2, 1, 6);
        set_exp(5, 31, 14, -19);
        run_job("k3", 3, 1'b0, 1'b0, 1'b0, 7, 11);
        run_job("k3_bubble", 3, 1'b1, 1'b1, 1'b0, -1, -1);

        // zero length
        set_exp(0, 0, 0, 0);
        run_job("zero", 0, 1'b0, 1'b0, 1'b0, -1, -1);

        // abort mid-LOAD, then a fresh job with a start pulse during DRAIN
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(3);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = {8'd9, 8'd9};
        in_b = {8'd9, 8'd9};
        @(negedge clk);
        check("abort.busy_before", busy, 1);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.in_ready", in_ready, 0);
        check("abort.out_valid", out_valid, 0);
        set_beat(0, 2, 3, 4, 5);
        set_exp(8, 10, 12, 15);
        run_job("fresh", 1, 1'b0, 1'b0, 1'b1, 5, 9);

        run_sat();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
